// File: rtl/vliw_regfile_sb.sv
// Two-write-slot VLIW register file with four read ports, optional write-to-read
// bypass, a per-register pending scoreboard and a registered write-collision flag.
module vliw_regfile_sb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_we,
  input  logic [ADDR_W-1:0]      alu_wa,
  input  logic [DATA_W-1:0]      alu_wd,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_wa,
  input  logic [DATA_W-1:0]      mem_wd,
  input  logic [ADDR_W-1:0]      alu_rm_a,
  input  logic [ADDR_W-1:0]      alu_rn_a,
  input  logic [ADDR_W-1:0]      mem_rn_a,
  input  logic [ADDR_W-1:0]      mem_rd_a,
  output logic [DATA_W-1:0]      alu_rm_q,
  output logic [DATA_W-1:0]      alu_rn_q,
  output logic [DATA_W-1:0]      mem_rn_q,
  output logic [DATA_W-1:0]      mem_rd_q,
  output logic                   alu_rm_hz,
  output logic                   alu_rn_hz,
  output logic                   mem_rn_hz,
  output logic                   mem_rd_hz,
  input  logic                   iss_alu_v,
  input  logic [ADDR_W-1:0]      iss_alu_rd,
  input  logic                   iss_mem_v,
  input  logic [ADDR_W-1:0]      iss_mem_rd,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   wr_collision
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              coll_q, coll_d;

  logic [ADDR_W-1:0] ra  [4];
  logic [DATA_W-1:0] rq  [4];
  logic [3:0]        rhz;

  // MEM slot is applied last so it wins a same-address write.
  always_comb begin
    regs_d = regs_q;
    if (alu_we) regs_d[alu_wa] = alu_wd;
    if (mem_we) regs_d[mem_wa] = mem_wd;
    if (R0_ZERO) regs_d[0] = '0;
  end

  assign coll_d = alu_we && mem_we && (alu_wa == mem_wa);

  always_comb begin
    pending_d = pending_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if ((iss_alu_v && iss_alu_rd == ADDR_W'(r)) || (iss_mem_v && iss_mem_rd == ADDR_W'(r)))
        pending_d[r] = 1'b1;
      else if ((alu_we && alu_wa == ADDR_W'(r)) || (mem_we && mem_wa == ADDR_W'(r)))
        pending_d[r] = 1'b0;
    end
    if (flush) pending_d = '0;
    if (R0_ZERO) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
      pending_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      coll_q    <= coll_d;
    end
  end

  assign ra[0] = alu_rm_a;
  assign ra[1] = alu_rn_a;
  assign ra[2] = mem_rn_a;
  assign ra[3] = mem_rd_a;

  // A bypassed read also masks the hazard, since the producer's data is on the wire now.
  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      rq[p]  = regs_q[ra[p]];
      rhz[p] = pending_q[ra[p]];
      if (BYPASS && alu_we && alu_wa == ra[p]) begin
        rq[p]  = alu_wd;
        rhz[p] = 1'b0;
      end
      if (BYPASS && mem_we && mem_wa == ra[p]) begin
        rq[p]  = mem_wd;
        rhz[p] = 1'b0;
      end
      if (R0_ZERO && ra[p] == '0) begin
        rq[p]  = '0;
        rhz[p] = 1'b0;
      end
    end
  end

  assign alu_rm_q     = rq[0];
  assign alu_rn_q     = rq[1];
  assign mem_rn_q     = rq[2];
  assign mem_rd_q     = rq[3];
  assign alu_rm_hz    = rhz[0];
  assign alu_rn_hz    = rhz[1];
  assign mem_rn_hz    = rhz[2];
  assign mem_rd_hz    = rhz[3];
  assign pending      = pending_q;
  assign wr_collision = coll_q;

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Bench for vliw_regfile_sb: three instances (bypass, no bypass, r0-zero) share stimulus.
module tb_vliw_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_we, mem_we;
  logic [2:0]  alu_wa, mem_wa;
  logic [31:0] alu_wd, mem_wd;
  logic [2:0]  rd_a [4];
  logic        iss_alu_v, iss_mem_v, flush;
  logic [2:0]  iss_alu_rd, iss_mem_rd;

  logic [31:0] q_b [4], q_n [4], q_z [4];
  logic [3:0]  hz_b, hz_n, hz_z;
  logic [7:0]  pend_b, pend_n, pend_z;
  logic        coll_b, coll_n, coll_z;

  always #5 clk = ~clk;

  vliw_regfile_sb #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm_a(rd_a[0]), .alu_rn_a(rd_a[1]), .mem_rn_a(rd_a[2]), .mem_rd_a(rd_a[3]),
    .alu_rm_q(q_b[0]), .alu_rn_q(q_b[1]), .mem_rn_q(q_b[2]), .mem_rd_q(q_b[3]),
    .alu_rm_hz(hz_b[0]), .alu_rn_hz(hz_b[1]), .mem_rn_hz(hz_b[2]), .mem_rd_hz(hz_b[3]),
    .iss_alu_v(iss_alu_v), .iss_alu_rd(iss_alu_rd),
    .iss_mem_v(iss_mem_v), .iss_mem_rd(iss_mem_rd),
    .flush(flush), .pending(pend_b), .wr_collision(coll_b));

  vliw_regfile_sb #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b0), .R0_ZERO(1'b0)) dut_n (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm_a(rd_a[0]), .alu_rn_a(rd_a[1]), .mem_rn_a(rd_a[2]), .mem_rd_a(rd_a[3]),
    .alu_rm_q(q_n[0]), .alu_rn_q(q_n[1]), .mem_rn_q(q_n[2]), .mem_rd_q(q_n[3]),
    .alu_rm_hz(hz_n[0]), .alu_rn_hz(hz_n[1]), .mem_rn_hz(hz_n[2]), .mem_rd_hz(hz_n[3]),
    .iss_alu_v(iss_alu_v), .iss_alu_rd(iss_alu_rd),
    .iss_mem_v(iss_mem_v), .iss_mem_rd(iss_mem_rd),
    .flush(flush), .pending(pend_n), .wr_collision(coll_n));

  vliw_regfile_sb #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_rm_a(rd_a[0]), .alu_rn_a(rd_a[1]), .mem_rn_a(rd_a[2]), .mem_rd_a(rd_a[3]),
    .alu_rm_q(q_z[0]), .alu_rn_q(q_z[1]), .mem_rn_q(q_z[2]), .mem_rd_q(q_z[3]),
    .alu_rm_hz(hz_z[0]), .alu_rn_hz(hz_z[1]), .mem_rn_hz(hz_z[2]), .mem_rd_hz(hz_z[3]),
    .iss_alu_v(iss_alu_v), .iss_alu_rd(iss_alu_rd),
    .iss_mem_v(iss_mem_v), .iss_mem_rd(iss_mem_rd),
    .flush(flush), .pending(pend_z), .wr_collision(coll_z));

  // One cycle of stimulus; eq/ehz are same-cycle read results, epend/ecoll are post-edge.
  typedef struct {
    string       nm;
    logic        awe; logic [2:0] awa; logic [31:0] awd;
    logic        mwe; logic [2:0] mwa; logic [31:0] mwd;
    logic        iav; logic [2:0] iar;
    logic        imv; logic [2:0] imr;
    logic        fl;  logic [2:0] ra;
    logic [31:0] eq_b; logic ehz_b;
    logic [31:0] eq_n; logic ehz_n;
    logic [7:0]  epend; logic ecoll;
  } vec_t;

  typedef struct {
    string      nm;
    logic [7:0] pend_b;
    logic [7:0] pend_z;
    logic       coll;
  } sb_t;

  vec_t vt [$];
  sb_t  sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(string nm,
      logic awe, logic [2:0] awa, logic [31:0] awd,
      logic mwe, logic [2:0] mwa, logic [31:0] mwd,
      logic iav, logic [2:0] iar, logic imv, logic [2:0] imr,
      logic fl, logic [2:0] ra,
      logic [31:0] eq_b, logic ehz_b, logic [31:0] eq_n, logic ehz_n,
      logic [7:0] epend, logic ecoll);
    vec_t v;
    v.nm = nm; v.awe = awe; v.awa = awa; v.awd = awd;
    v.mwe = mwe; v.mwa = mwa; v.mwd = mwd;
    v.iav = iav; v.iar = iar; v.imv = imv; v.imr = imr;
    v.fl = fl; v.ra = ra;
    v.eq_b = eq_b; v.ehz_b = ehz_b; v.eq_n = eq_n; v.ehz_n = ehz_n;
    v.epend = epend; v.ecoll = ecoll;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_we = 1'b0; mem_wa = '0; mem_wd = '0;
    iss_alu_v = 1'b0; iss_alu_rd = '0;
    iss_mem_v = 1'b0; iss_mem_rd = '0;
    for (int p = 0; p < 4; p++) rd_a[p] = '0;
  endtask

  task automatic set_ra(logic [2:0] a);
    for (int p = 0; p < 4; p++) rd_a[p] = a;
  endtask

  task automatic check_sb();
    sb_t e;
    if (sbq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    chk({e.nm, ".pend_b"}, {24'h0, pend_b}, {24'h0, e.pend_b});
    chk({e.nm, ".pend_n"}, {24'h0, pend_n}, {24'h0, e.pend_b});
    chk({e.nm, ".pend_z"}, {24'h0, pend_z}, {24'h0, e.pend_z});
    chk({e.nm, ".coll_b"}, {31'h0, coll_b}, {31'h0, e.coll});
    chk({e.nm, ".coll_n"}, {31'h0, coll_n}, {31'h0, e.coll});
    chk({e.nm, ".coll_z"}, {31'h0, coll_z}, {31'h0, e.coll});
  endtask

  task automatic apply(vec_t v);
    sb_t e;
    alu_we = v.awe; alu_wa = v.awa; alu_wd = v.awd;
    mem_we = v.mwe; mem_wa = v.mwa; mem_wd = v.mwd;
    iss_alu_v = v.iav; iss_alu_rd = v.iar;
    iss_mem_v = v.imv; iss_mem_rd = v.imr;
    flush = v.fl; set_ra(v.ra);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s.q_b%0d", v.nm, p), q_b[p], v.eq_b);
      chk($sformatf("%s.hz_b%0d", v.nm, p), {31'h0, hz_b[p]}, {31'h0, v.ehz_b});
      chk($sformatf("%s.q_n%0d", v.nm, p), q_n[p], v.eq_n);
      chk($sformatf("%s.hz_n%0d", v.nm, p), {31'h0, hz_n[p]}, {31'h0, v.ehz_n});
      chk($sformatf("%s.q_z%0d", v.nm, p), q_z[p], v.eq_b);
    end
    e.nm = v.nm; e.pend_b = v.epend; e.pend_z = v.epend; e.coll = v.ecoll;
    sbq.push_back(e);
    @(posedge clk); #1;
    check_sb();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          nm          awe awa  awd           mwe mwa mwd   iav iar  imv imr  fl ra   eq_b          hzb eq_n          hzn pend   coll
    vt.push_back(mk("byp",      1, 3, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0, 32'h0,        0, 8'h00, 0));
    vt.push_back(mk("byp_nx",   0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 8'h00, 0));
    vt.push_back(mk("coll",     1, 5, 1,            1, 5, 2,      0, 0, 0, 0, 0, 5, 32'h2,        0, 32'h0,        0, 8'h00, 1));
    vt.push_back(mk("coll_nx",  0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0, 5, 32'h2,        0, 32'h2,        0, 8'h00, 0));
    vt.push_back(mk("iss_mem",  0, 0, 0,            0, 0, 0,      0, 0, 1, 4, 0, 4, 32'h0,        0, 32'h0,        0, 8'h10, 0));
    vt.push_back(mk("hz",       0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0, 4, 32'h0,        1, 32'h0,        1, 8'h10, 0));
    vt.push_back(mk("wb_set",   0, 0, 0,            1, 4, 32'h44, 1, 4, 0, 0, 0, 4, 32'h44,       0, 32'h0,        1, 8'h10, 0));
    vt.push_back(mk("wb_clr",   0, 0, 0,            1, 4, 32'h45, 0, 0, 0, 0, 0, 4, 32'h45,       0, 32'h44,       1, 8'h00, 0));
    vt.push_back(mk("after_wb", 0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0, 4, 32'h45,       0, 32'h45,       0, 8'h00, 0));
    vt.push_back(mk("iss_12",   0, 0, 0,            0, 0, 0,      1, 1, 1, 2, 0, 1, 32'h0,        0, 32'h0,        0, 8'h06, 0));
    vt.push_back(mk("iss_56",   0, 0, 0,            0, 0, 0,      1, 5, 1, 6, 0, 2, 32'h0,        1, 32'h0,        1, 8'h66, 0));
    vt.push_back(mk("flush",    0, 0, 0,            0, 0, 0,      1, 0, 0, 0, 1, 5, 32'h2,        1, 32'h2,        1, 8'h00, 0));
    vt.push_back(mk("same_rd",  0, 0, 0,            0, 0, 0,      1, 7, 1, 7, 0, 7, 32'h0,        0, 32'h0,        0, 8'h80, 0));
    vt.push_back(mk("wb_two",   1, 7, 32'h77,       1, 6, 32'h66, 0, 0, 0, 0, 0, 7, 32'h77,       0, 32'h0,        1, 8'h00, 0));
    vt.push_back(mk("rd6",      0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0, 6, 32'h66,       0, 32'h66,       0, 8'h00, 0));
    vt.push_back(mk("wb_nopnd", 1, 2, 32'h22,       0, 0, 0,      0, 0, 0, 0, 0, 2, 32'h22,       0, 32'h0,        0, 8'h00, 0));

    idle();
    reset = 1'b1;
    alu_we = 1'b1; alu_wa = 3'd2; alu_wd = 32'hFFFF;
    iss_alu_v = 1'b1; iss_alu_rd = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      set_ra(3'(a));
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rst.q_b%0d_a%0d", p, a), q_b[p], 32'h0);
        chk($sformatf("rst.q_n%0d_a%0d", p, a), q_n[p], 32'h0);
        chk($sformatf("rst.q_z%0d_a%0d", p, a), q_z[p], 32'h0);
      end
    end
    chk("rst.pend_b", {24'h0, pend_b}, 32'h0);
    chk("rst.pend_n", {24'h0, pend_n}, 32'h0);
    chk("rst.coll_b", {31'h0, coll_b}, 32'h0);
    idle();
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    // Reset mid-operation: pending set, then reset with writes, issues and a collision.
    iss_alu_v = 1'b1; iss_alu_rd = 3'd3;
    sbq.push_back('{nm: "pre_rst", pend_b: 8'h08, pend_z: 8'h08, coll: 1'b0});
    @(posedge clk); #1;
    check_sb();
    idle();
    reset = 1'b1;
    alu_we = 1'b1; alu_wa = 3'd1; alu_wd = 32'hAAAA;
    mem_we = 1'b1; mem_wa = 3'd1; mem_wd = 32'hBBBB;
    iss_alu_v = 1'b1; iss_alu_rd = 3'd5;
    iss_mem_v = 1'b1; iss_mem_rd = 3'd4;
    sbq.push_back('{nm: "mid_rst", pend_b: 8'h00, pend_z: 8'h00, coll: 1'b0});
    @(posedge clk); #1;
    check_sb();
    idle();
    for (int a = 1; a < 8; a += 2) begin
      set_ra(3'(a));
      #1;
      chk($sformatf("mid_rst.q_b_a%0d", a), q_b[0], 32'h0);
      chk($sformatf("mid_rst.q_n_a%0d", a), q_n[3], 32'h0);
    end
    idle();
    @(posedge clk); #1;

    // r0 handling: only the R0_ZERO instance discards the write and the issue.
    alu_we = 1'b1; alu_wa = 3'd0; alu_wd = 32'h55;
    iss_alu_v = 1'b1; iss_alu_rd = 3'd0;
    set_ra(3'd0);
    @(negedge clk);
    chk("r0.q_z_same", q_z[1], 32'h0);
    chk("r0.q_b_same", q_b[1], 32'h55);
    sbq.push_back('{nm: "r0_iss", pend_b: 8'h01, pend_z: 8'h00, coll: 1'b0});
    @(posedge clk); #1;
    check_sb();
    idle();
    set_ra(3'd0);
    #1;
    chk("r0.q_z_next", q_z[2], 32'h0);
    chk("r0.q_b_next", q_b[2], 32'h55);
    chk("r0.hz_z_next", {31'h0, hz_z[2]}, 32'h0);
    chk("r0.hz_b_next", {31'h0, hz_b[2]}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vliw_regfile_sb.md
Name: vliw_regfile_sb

Overview:
- Parametrised two-write-slot register file for the VLIW datapath, with four read ports: two for the ALU slot and two for the MEM slot.
- Adds three things the fixed 8x32 file does not have: a same-cycle write-to-read bypass, a per-register pending scoreboard for hazard detection, and a registered write-collision flag.
- Sits between decode and the ALU/MEM operand muxes. Writeback comes from both slots.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 3, register address width. NREGS = 2**ADDR_W.
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only.
- R0_ZERO, 0, 1 = register 0 reads as 0 and ignores writes and issues.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- alu_we  in  1  ALU-slot write enable
- alu_wa  in  ADDR_W  ALU-slot write address
- alu_wd  in  DATA_W  ALU-slot write data
- mem_we  in  1  MEM-slot write enable
- mem_wa  in  ADDR_W  MEM-slot write address
- mem_wd  in  DATA_W  MEM-slot write data
- alu_rm_a, alu_rn_a, mem_rn_a, mem_rd_a  in  ADDR_W each  read addresses
- alu_rm_q, alu_rn_q, mem_rn_q, mem_rd_q  out  DATA_W each  read data, combinational
- alu_rm_hz, alu_rn_hz, mem_rn_hz, mem_rd_hz  out  1 each  operand hazard, combinational
- iss_alu_v  in  1  ALU-slot instruction issued with a register destination
- iss_alu_rd  in  ADDR_W  its destination
- iss_mem_v  in  1  MEM-slot instruction issued with a register destination (loads)
- iss_mem_rd  in  ADDR_W  its destination
- flush  in  1  pipeline flush: drop all pending destinations
- pending  out  NREGS  scoreboard bit per register
- wr_collision  out  1  registered pulse: both slots wrote the same address

Behaviour:
- Reset (sync, dominates everything):
  - all registers = 0, pending = 0, wr_collision = 0.
  - Writes, issues and flush in a reset cycle are ignored.
- Writes:
  - Take effect at the rising edge. Data is readable from the next cycle, or in the same cycle if BYPASS=1.
  - Both enables set with alu_wa == mem_wa: MEM slot wins. wr_collision = 1 for exactly the following cycle; otherwise it is 0 that cycle.
  - Different addresses: both writes commit.
- Reads:
  - Purely combinational; any number of ports may read the same address.
  - BYPASS=1 and the read address matches an active write: return write data, MEM data if both slots match.
  - BYPASS=0: return the stored value.
  - R0_ZERO=1: address 0 always returns 0.
- Scoreboard, per register r, next-state priority:
  1. reset -> 0
  2. flush -> 0 (issues in the same cycle are discarded)
  3. set if iss_alu_v&&iss_alu_rd==r, or iss_mem_v&&iss_mem_rd==r. Set wins over a same-cycle writeback clear because a newer producer exists.
  4. clear if (alu_we&&alu_wa==r) or (mem_we&&mem_wa==r)
  5. hold
- Both issue ports naming the same rd: one bit set, no error.
- Writeback to a register whose pending bit is 0: write commits, bit stays 0.
- R0_ZERO=1: pending[0] is constant 0.
- Hazard output for port p = pending[addr_p] && !(BYPASS && an active write to addr_p this cycle). With BYPASS=0 the hazard holds until the cycle after writeback.
- Latency:
  - write-to-read: 0 cycles with bypass, 1 cycle without.
  - issue-to-pending: 1 cycle.
  - writeback-to-pending-clear: 1 cycle.
  - wr_collision: 1 cycle.

Test Plan:
- Reset, then read all four ports at addresses 0..7 -> all q = 0, pending = 8'h00, wr_collision = 0.
- BYPASS=1: cycle 0 alu_we=1, alu_wa=3, alu_wd=32'hDEADBEEF, alu_rm_a=3 -> alu_rm_q=DEADBEEF in cycle 0. Same stimulus with BYPASS=0 -> q is the old value in cycle 0 and DEADBEEF in cycle 1.
- Collision: alu_we=mem_we=1, both addresses 5, alu_wd=1, mem_wd=2 -> r5 reads 2 next cycle; wr_collision=1 for exactly one cycle, then 0.
- Scoreboard:
  - Setup: iss_mem_v=1, iss_mem_rd=4 -> pending=8'h10 next cycle; mem_rn_a=4 gives mem_rn_hz=1.
  - Writeback: mem_we=1, mem_wa=4 -> with BYPASS=1, hz=0 in the writeback cycle; pending=8'h00 next cycle.
  - Set-over-clear: iss_alu_rd=4 issued in the same cycle as that writeback -> pending[4] stays 1.
- Flush: pending=8'h66 plus iss_alu_v=1, iss_alu_rd=0 and flush=1 in the same cycle -> pending=8'h00 next cycle.
- Reset mid-operation: writes, issues and a collision active in the reset cycle -> registers 0, pending 0, wr_collision 0 next cycle. R0_ZERO=1: write 32'h55 to r0 -> reads 0, pending[0] stays 0 after an issue to rd 0.
